// File: rtl/mux_n_1_reg_if.sv
// Handshake bundle for mux_n_1_reg: N producer channels in, one registered consumer channel out.
// master = producers/consumer side, slave = the mux.
interface mux_n_1_reg_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4
);
  localparam int SEL_W = $clog2(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_src;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_src, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_src, out_valid
  );
endinterface

// File: rtl/mux_n_1_reg.sv
// N-to-1 registered mux with valid/ready per channel; explicit-select or round-robin grant.
// Optional MUX_PARITY_EN adds a registered even-parity output of out_data.
module mux_n_1_reg #(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [$clog2(N)-1:0] Select,
  input  logic                 mode,
`ifdef MUX_PARITY_EN
  output logic                 out_parity,
`endif
  mux_n_1_reg_if.slave         bus
);
  localparam int SEL_W = $clog2(N);

  logic [WIDTH-1:0] ch_data [N];
  logic [N-1:0]     in_ready_vec;
  logic [SEL_W-1:0] grant_idx;
  logic             grant_found;
  logic             can_load;
  logic             load;
  int               scan_idx;

  logic [SEL_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [WIDTH-1:0] out_data_reg;
  logic [SEL_W-1:0] out_src_reg;
  logic             out_valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      assign ch_data[gi]      = bus.in_data[gi*WIDTH +: WIDTH];
      assign in_ready_vec[gi] = load && (grant_idx == SEL_W'(gi));
    end
  endgenerate

  assign can_load = !out_valid_reg || bus.out_ready;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    if (!mode) begin
      if ((int'(Select) < N) && bus.in_valid[Select]) begin
        grant_found = 1'b1;
        grant_idx   = Select;
      end
    end else begin
      // First valid channel at or after rr_ptr, wrapping modulo N.
      for (int k = 0; k < N; k++) begin
        scan_idx = (int'(rr_ptr_reg) + k) % N;
        if (!grant_found && bus.in_valid[SEL_W'(scan_idx)]) begin
          grant_found = 1'b1;
          grant_idx   = SEL_W'(scan_idx);
        end
      end
    end
  end

  // rst_n gating keeps every in_ready low while reset is held.
  assign load        = grant_found && can_load && rst_n;
  assign rr_ptr_next = (grant_idx == SEL_W'(N-1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_reg  <= '0;
      out_src_reg   <= '0;
      out_valid_reg <= 1'b0;
      rr_ptr_reg    <= '0;
    end else begin
      if (load) begin
        out_data_reg  <= ch_data[grant_idx];
        out_src_reg   <= grant_idx;
        out_valid_reg <= 1'b1;
        if (mode) begin
          rr_ptr_reg <= rr_ptr_next;
        end
      end else if (out_valid_reg && bus.out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

`ifdef MUX_PARITY_EN
  logic parity_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_reg <= 1'b0;
    end else if (load) begin
      parity_reg <= ^ch_data[grant_idx];
    end
  end

  assign out_parity = parity_reg;
`endif

  assign bus.in_ready  = in_ready_vec;
  assign bus.out_data  = out_data_reg;
  assign bus.out_src   = out_src_reg;
  assign bus.out_valid = out_valid_reg;
endmodule

// File: tb/tb_mux_n_1_reg.sv
// Bench for mux_n_1_reg: a cycle model of the N=4 instance checked every cycle, plus
// directed literal checks on an N=4 and an N=3 instance.
module tb_mux_n_1_reg;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] sel4 = 2'd0;
  logic       mode4 = 1'b0;
  logic [1:0] sel3 = 2'd0;
  logic       mode3 = 1'b0;
  int         errors = 0;
  int         checks = 0;
`ifdef MUX_PARITY_EN
  logic       par4;
  logic       par3;
`endif

  always #5 clk = ~clk;

  mux_n_1_reg_if #(.WIDTH(32), .N(4)) bus4 ();
  mux_n_1_reg_if #(.WIDTH(32), .N(3)) bus3 ();

  mux_n_1_reg #(.WIDTH(32), .N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .Select(sel4), .mode(mode4),
`ifdef MUX_PARITY_EN
    .out_parity(par4),
`endif
    .bus(bus4)
  );

  mux_n_1_reg #(.WIDTH(32), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .Select(sel3), .mode(mode3),
`ifdef MUX_PARITY_EN
    .out_parity(par3),
`endif
    .bus(bus3)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Channel the rules would grant, ignoring output occupancy; -1 means none.
  function automatic int pick(input logic [3:0] v, input logic m, input logic [1:0] s, input int ptr);
    if (!m) return v[s] ? int'(s) : -1;
    for (int k = 0; k < 4; k++) begin
      if (v[2'((ptr + k) % 4)]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  // Model of the N=4 instance: output slot plus round-robin pointer.
  logic        m_valid = 1'b0;
  logic [31:0] m_data  = '0;
  int          m_src   = 0;
  int          m_ptr   = 0;

  initial begin : compare
    int          g;
    logic [31:0] g_data;
    logic        g_mode;
    logic        g_ordy;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = 0;
      end
      g_ordy = bus4.out_ready;
      g_mode = mode4;
      g = -1;
      if (rst_n && (!m_valid || g_ordy)) g = pick(bus4.in_valid, mode4, sel4, m_ptr);
      g_data = (g >= 0) ? bus4.in_data[g*32 +: 32] : 32'h0;
      chk("model_in_ready", {60'h0, bus4.in_ready}, (g >= 0) ? (64'h1 << g) : 64'h0);
      chk("model_out_valid", {63'h0, bus4.out_valid}, {63'h0, m_valid});
      chk("model_out_data", {32'h0, bus4.out_data}, {32'h0, m_data});
      chk("model_out_src", {62'h0, bus4.out_src}, 64'(m_src));
`ifdef MUX_PARITY_EN
      chk("model_parity", {63'h0, par4}, {63'h0, ^m_data});
`endif
      @(posedge clk);
      if (!rst_n) begin
        m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = 0;
      end else if (g >= 0) begin
        m_valid = 1'b1; m_data = g_data; m_src = g;
        if (g_mode) m_ptr = (g + 1) % 4;
      end else if (m_valid && g_ordy) begin
        m_valid = 1'b0;
      end
    end
  end

  initial begin : stimulus
    int seq [6] = '{0, 1, 2, 3, 0, 1};
    int ord [4] = '{3, 0, 3, 0};
    bus4.in_data = '0; bus4.in_valid = '0; bus4.out_ready = 1'b1;
    bus3.in_data = '0; bus3.in_valid = '0; bus3.out_ready = 1'b1;
    repeat (2) step();
    chk("reset_valid", {63'h0, bus4.out_valid}, 64'h0);
    chk("reset_in_ready", {60'h0, bus4.in_ready}, 64'h0);
    rst_n = 1'b1;

    // Explicit select of channel 2.
    mode4 = 1'b0; sel4 = 2'd2;
    bus4.in_data[2*32 +: 32] = 32'hDEADBEEF; bus4.in_valid = 4'b0100;
    #1 chk("sel2_in_ready", {60'h0, bus4.in_ready}, 64'h4);
    step();
    $display("sel2: data=%h src=%0d valid=%0b", bus4.out_data, bus4.out_src, bus4.out_valid);
    chk("sel2_data", {32'h0, bus4.out_data}, 64'hDEADBEEF);
    chk("sel2_src", {62'h0, bus4.out_src}, 64'h2);
    chk("sel2_valid", {63'h0, bus4.out_valid}, 64'h1);
    bus4.in_valid = 4'b0000;
    #1 chk("sel2_idle_ready", {60'h0, bus4.in_ready}, 64'h0);
    step();
    chk("sel2_drained", {63'h0, bus4.out_valid}, 64'h0);

    // Round-robin over all channels.
    for (int i = 0; i < 4; i++) bus4.in_data[i*32 +: 32] = 32'hA0 + 32'(i);
    mode4 = 1'b1; bus4.in_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      step();
      $display("rr%0d: src=%0d data=%h valid=%0b", k, bus4.out_src, bus4.out_data, bus4.out_valid);
      chk("rr_src", {62'h0, bus4.out_src}, 64'(seq[k]));
      chk("rr_valid", {63'h0, bus4.out_valid}, 64'h1);
    end
    bus4.in_valid = 4'b0001;   // pointer 2 -> grant 0 -> pointer 1
    step();
    bus4.in_valid = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      step();
      $display("rr1001_%0d: src=%0d", k, bus4.out_src);
      chk("rr1001_src", {62'h0, bus4.out_src}, 64'(ord[k]));
    end

    // Back-pressure for three cycles.
    bus4.out_ready = 1'b0; bus4.in_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_in_ready", {60'h0, bus4.in_ready}, 64'h0);
      step();
      chk("bp_data", {32'h0, bus4.out_data}, 64'hA0);
      chk("bp_src", {62'h0, bus4.out_src}, 64'h0);
      chk("bp_valid", {63'h0, bus4.out_valid}, 64'h1);
    end
    bus4.out_ready = 1'b1;
    #1 chk("bp_release_ready", {60'h0, bus4.in_ready}, 64'h2);
    step();
    $display("bp_release: src=%0d valid=%0b", bus4.out_src, bus4.out_valid);
    chk("bp_release_src", {62'h0, bus4.out_src}, 64'h1);
    chk("bp_release_valid", {63'h0, bus4.out_valid}, 64'h1);

    // Asynchronous reset with a word pending.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    $display("async_rst: valid=%0b data=%h src=%0d", bus4.out_valid, bus4.out_data, bus4.out_src);
    chk("arst_valid", {63'h0, bus4.out_valid}, 64'h0);
    chk("arst_data", {32'h0, bus4.out_data}, 64'h0);
    chk("arst_src", {62'h0, bus4.out_src}, 64'h0);
    chk("arst_in_ready", {60'h0, bus4.in_ready}, 64'h0);
    step();
    rst_n = 1'b1;
    #1 chk("post_rst_ready", {60'h0, bus4.in_ready}, 64'h1);
    step();
    chk("post_rst_src", {62'h0, bus4.out_src}, 64'h0);
    chk("post_rst_data", {32'h0, bus4.out_data}, 64'hA0);
    bus4.in_valid = 4'b0000;

    // N=3 instance: out-of-range select never grants, in-range select does.
    for (int i = 0; i < 3; i++) bus3.in_data[i*32 +: 32] = 32'hC0 + 32'(i);
    mode3 = 1'b0; sel3 = 2'd3; bus3.in_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      #1 chk("n3_oor_ready", {61'h0, bus3.in_ready}, 64'h0);
      step();
      chk("n3_oor_valid", {63'h0, bus3.out_valid}, 64'h0);
    end
    sel3 = 2'd2;
    #1 chk("n3_sel2_ready", {61'h0, bus3.in_ready}, 64'h4);
    step();
    $display("n3_sel2: data=%h src=%0d", bus3.out_data, bus3.out_src);
    chk("n3_sel2_data", {32'h0, bus3.out_data}, 64'hC2);
    bus3.in_valid = 3'b000;

`ifdef MUX_PARITY_EN
    mode4 = 1'b0; sel4 = 2'd0;
    bus4.in_data[31:0] = 32'h00000007; bus4.in_valid = 4'b0001;
    step();
    $display("parity 7: %0b", par4);
    chk("parity_7", {63'h0, par4}, 64'h1);
    bus4.in_data[31:0] = 32'h00000003;
    step();
    $display("parity 3: %0b", par4);
    chk("parity_3", {63'h0, par4}, 64'h0);
    bus4.in_valid = 4'b0000;
`endif

    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
